axi4_wr_arbiter: RTL

Two-requester write scheduler that shares the single AXI4 write path (AW/W/B) of the memory-test master between two burst sources, such as the FIFO-fed test writer and a host register-write engine. It grants one whole burst at a time using round-robin order and sequences address, data and response phases. It returns a per-requester completion pulse with error status. The enclosing master wrapper drives AWSIZE (full bus width), AWBURST (INCR) and WSTRB (all ones) as constants.

---
 rtl/axi4_wr_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/axi4_wr_arbiter.sv
// Round-robin scheduler that shares one AXI4 write channel (AW/W/B) between two
// burst requesters, with one whole burst outstanding at a time.
module axi4_wr_arbiter #(
   parameter int ADDR_BUS_WIDTH = 32,
   parameter int DATA_BUS_WIDTH = 32,
   parameter int ID_WIDTH       = 4
) (
   input  logic                        m_axi_aclk,
   input  logic                        m_axi_areset,
   input  logic [1:0]                  req_valid,
   input  logic [2*ADDR_BUS_WIDTH-1:0] req_addr,
   input  logic [15:0]                 req_len,
   output logic [1:0]                  req_ready,
   input  logic [2*DATA_BUS_WIDTH-1:0] wr_data,
   input  logic [1:0]                  wr_valid,
   output logic [1:0]                  wr_ready,
   output logic [1:0]                  grant,
   output logic [1:0]                  done,
   output logic [1:0]                  done_err,
   output logic [ID_WIDTH-1:0]         m_axi_awid,
   output logic [ADDR_BUS_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]                  m_axi_awlen,
   output logic                        m_axi_awvalid,
   input  logic                        m_axi_awready,
   output logic [DATA_BUS_WIDTH-1:0]   m_axi_wdata,
   output logic                        m_axi_wlast,
   output logic                        m_axi_wvalid,
   input  logic                        m_axi_wready,
   input  logic [ID_WIDTH-1:0]         m_axi_bid,
   input  logic [1:0]                  m_axi_bresp,
   input  logic                        m_axi_bvalid,
   output logic                        m_axi_bready
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t                         state, state_nxt;
   logic [1:0][ADDR_BUS_WIDTH-1:0] addr_v;
   logic [1:0][7:0]                len_v;
   logic [1:0][DATA_BUS_WIDTH-1:0] data_v;
   logic                           gidx, last_grant, win, accept, w_hs;
   logic [7:0]                     beat_cnt;
   logic                           bresp_unused;

   assign addr_v       = req_addr;
   assign len_v        = req_len;
   assign data_v       = wr_data;
   assign bresp_unused = m_axi_bresp[0];

   // On a tie the requester that did not own the previous burst wins.
   always_comb begin
      case (req_valid)
         2'b10:   win = 1'b1;
         2'b11:   win = ~last_grant;
         default: win = 1'b0;
      endcase
   end

   assign accept = (state == IDLE) && (|req_valid) && !m_axi_areset;
   assign w_hs   = m_axi_wvalid && m_axi_wready;

   always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
      if (m_axi_areset) state <= IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)                   state_nxt = ADDR;
         ADDR:    if (m_axi_awready)            state_nxt = DATA;
         DATA:    if (w_hs && m_axi_wlast)      state_nxt = RESP;
         RESP:    if (m_axi_bvalid)             state_nxt = IDLE;
         default:                               state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready     = '0;
      wr_ready      = '0;
      grant         = '0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_wlast   = 1'b0;
      m_axi_bready  = 1'b0;
      m_axi_wdata   = data_v[gidx];
      if (accept)        req_ready[win] = 1'b1;
      if (state != IDLE) grant[gidx]    = 1'b1;
      case (state)
         ADDR: m_axi_awvalid = 1'b1;
         DATA: begin
            m_axi_wvalid   = wr_valid[gidx];
            wr_ready[gidx] = m_axi_wready;
            m_axi_wlast    = (beat_cnt == m_axi_awlen);
         end
         RESP: m_axi_bready = 1'b1;
         default: ;
      endcase
   end

   // Burst context: owner, latched command, beat counter, ID and completion.
   always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
      if (m_axi_areset) begin
         gidx         <= 1'b0;
         last_grant   <= 1'b1;
         m_axi_awid   <= '0;
         m_axi_awaddr <= '0;
         m_axi_awlen  <= '0;
         beat_cnt     <= '0;
         done         <= '0;
         done_err     <= '0;
      end else begin
         done     <= '0;
         done_err <= '0;
         case (state)
            IDLE: if (accept) begin
               gidx         <= win;
               m_axi_awaddr <= addr_v[win];
               m_axi_awlen  <= len_v[win];
               beat_cnt     <= '0;
            end
            DATA: if (w_hs) beat_cnt <= beat_cnt + 8'd1;
            RESP: if (m_axi_bvalid) begin
               done[gidx]     <= 1'b1;
               done_err[gidx] <= m_axi_bresp[1] | (m_axi_bid != m_axi_awid);
               m_axi_awid     <= m_axi_awid + ID_WIDTH'(1);
               last_grant     <= gidx;
            end
            default: ;
         endcase
      end
   end

endmodule
